mac_stop_seq: RTL and testbench
===============================

MAC_STOP_SEQ -- requirements
Module: mac_stop_seq

Interface
REQ-001 Parameters (name, default, meaning) SHALL be as follows:
- M, 4, rows of A and C.
- K, 4, inner dimension.
- N, 4, columns of B and C.
- DATA_WIDTH_INIT_MATRIX, 32, A/B element width.
- DATA_WIDTH_RESULT_MATRIX, 2*DATA_WIDTH_INIT_MATRIX+$clog2(K), C element width.

REQ-002 Ports (name, direction, width, meaning) SHALL be as follows:
- clk, in, 1, sole clock; all logic on rising edge.
- reset, in, 1, synchronous active-high reset.
- start, in, 1, request one full C = A x B pass.
- busy, out, 1, high from the cycle after start is accepted until done.
- done, out, 1, one-cycle completion pulse.
- row_addr_a, out, $clog2(M), A row address.
- col_addr_a, out, $clog2(K), A column address.
- matrix_a_re, out, 1, A read enable.
- data_out_a, in, DATA_WIDTH_INIT_MATRIX, A read data.
- row_addr_b, out, $clog2(K), B row address.
- col_addr_b, out, $clog2(N), B column address.
- matrix_b_re, out, 1, B read enable.
- data_out_b, in, DATA_WIDTH_INIT_MATRIX, B read data.
- row_addr_c, out, $clog2(M), C row address.
- col_addr_c, out, $clog2(N), C column address.
- matrix_c_we, out, 1, C write enable.
- data_in_c, out, DATA_WIDTH_RESULT_MATRIX, C write data.

Function
REQ-003 The block SHALL be the compute stage feeding mac_stop_mem: it reads A and B through the memory's read ports and writes results into C.
REQ-004 Memory read data SHALL be taken as valid exactly one cycle after the cycle in which re and the address are presented.
REQ-005 The FSM SHALL have these states: IDLE, FETCH, DRAIN, WRITE, DONE.
REQ-006 In IDLE, start=1 SHALL move the FSM to FETCH with i=j=k=0 and the accumulator cleared.
REQ-007 FETCH SHALL last K cycles; in cycle k it drives matrix_a_re=matrix_b_re=1, A address (i,k) and B address (k,j).
REQ-008 Each cycle after a FETCH cycle, the accumulator SHALL add data_out_a*data_out_b; the full product is extended to DATA_WIDTH_RESULT_MATRIX with no truncation.
REQ-009 DRAIN SHALL last 1 cycle, with re deasserted, and absorb the last product.
REQ-010 WRITE SHALL last 1 cycle and drive matrix_c_we=1, C address (i,j), and data_in_c equal to the accumulator.
REQ-011 After WRITE, the accumulator SHALL clear and the FSM SHALL advance in row-major order (j first, then i), returning to FETCH.
REQ-012 After WRITE of element (M-1,N-1), the FSM SHALL go to DONE.
REQ-013 DONE SHALL assert done=1 for one cycle, then return to IDLE.
REQ-014 Each element SHALL take exactly K+2 cycles; done SHALL assert M*N*(K+2)+1 cycles after the start edge (97 for 4/4/4).
REQ-015 start SHALL be ignored in every state except IDLE; no restart or queuing.
REQ-016 Outside FETCH, matrix_a_re and matrix_b_re SHALL be 0; outside WRITE, matrix_c_we SHALL be 0.
REQ-017 Addresses SHALL hold their last driven value when not in use.
REQ-018 Address counters SHALL never exceed M-1, K-1 or N-1; no wrap-around beyond one pass.

Reset
REQ-019 While reset=1 at a clk edge, the FSM SHALL enter IDLE and clear i, j, k and the accumulator.
REQ-020 While reset=1 at a clk edge, busy, done, all re/we and data_in_c SHALL be 0, and all addresses SHALL be 0.
REQ-021 Reset asserted mid-pass SHALL abort immediately; no further C writes occur, and a fresh start is required.
REQ-022 Reset SHALL take priority over start in the same cycle.

Configuration
REQ-023 With macro MAC_STOP_SEQ_SIGNED_EN defined, A/B SHALL be treated as two's-complement signed, with products and accumulator sign-extended.
REQ-024 Without MAC_STOP_SEQ_SIGNED_EN, all arithmetic SHALL be unsigned.

Verification
REQ-025 Scenario 1: reset=1 for 2 cycles -> all outputs 0 and busy=0; start pulse afterwards -> busy=1 next cycle.
REQ-026 Scenario 2: A={{4,3,2,5},{3,4,5,2},{5,2,4,3},{2,5,3,4}}, B={{7,6,5,8},{6,7,8,5},{8,5,7,6},{5,8,6,7}} -> C={{87,95,88,94},{95,87,94,88},{94,88,87,95},{88,94,95,87}}; exactly 16 matrix_c_we pulses; done on cycle 97.
REQ-027 Scenario 3: all A and B elements = 0xFFFFFFFF, unsigned -> every C element = 4*(2^32-1)^2, no overflow in 66 bits.
REQ-028 Scenario 4: start pulsed again at cycle 20 of a pass -> ignored; pass completes with an unchanged C and a single done pulse.
REQ-029 Scenario 5: reset asserted at cycle 30 -> next cycle IDLE with all outputs 0, no further we; new start -> full correct C.
REQ-030 Scenario 6 (MAC_STOP_SEQ_SIGNED_EN): A row 0 = {-1,2,-3,4}, B column 0 = {1,1,1,1} -> C[0][0] = 2 (two's complement).

Source files
------------

// File: rtl/mac_stop_seq.sv
// mac_stop_seq: computes C = A x B one multiply-accumulate per cycle over registered-read memories.
// Build macro MAC_STOP_SEQ_SIGNED_EN selects two's-complement A/B arithmetic (default unsigned).
`timescale 1ns/1ps
`default_nettype none

module mac_stop_seq #(
    parameter int M                        = 4,
    parameter int K                        = 4,
    parameter int N                        = 4,
    parameter int DATA_WIDTH_INIT_MATRIX   = 32,
    parameter int DATA_WIDTH_RESULT_MATRIX = 2*DATA_WIDTH_INIT_MATRIX+$clog2(K)
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                start,
    output logic                                busy,
    output logic                                done,
    output logic [$clog2(M)-1:0]                row_addr_a,
    output logic [$clog2(K)-1:0]                col_addr_a,
    output logic                                matrix_a_re,
    input  logic [DATA_WIDTH_INIT_MATRIX-1:0]   data_out_a,
    output logic [$clog2(K)-1:0]                row_addr_b,
    output logic [$clog2(N)-1:0]                col_addr_b,
    output logic                                matrix_b_re,
    input  logic [DATA_WIDTH_INIT_MATRIX-1:0]   data_out_b,
    output logic [$clog2(M)-1:0]                row_addr_c,
    output logic [$clog2(N)-1:0]                col_addr_c,
    output logic                                matrix_c_we,
    output logic [DATA_WIDTH_RESULT_MATRIX-1:0] data_in_c,
    output logic [2:0]                          dbg_state
);

    localparam int DW = DATA_WIDTH_INIT_MATRIX;
    localparam int RW = DATA_WIDTH_RESULT_MATRIX;
    localparam int MW = $clog2(M);
    localparam int KW = $clog2(K);
    localparam int NW = $clog2(N);

    localparam logic [MW-1:0] I_LAST = MW'(M-1);
    localparam logic [KW-1:0] K_LAST = KW'(K-1);
    localparam logic [NW-1:0] J_LAST = NW'(N-1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_DRAIN = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [MW-1:0]   r_i;
    logic [KW-1:0]   r_k;
    logic [NW-1:0]   r_j;
    logic [RW-1:0]   r_acc;
    logic            r_prod_vld;
    logic            w_last_elem;
    logic [RW-1:0]   w_prod_ext;

    // Operands are widened before multiplying so the full 2*DW product is kept.
`ifdef MAC_STOP_SEQ_SIGNED_EN
    logic signed [2*DW-1:0] w_prod;
    assign w_prod = $signed({{DW{data_out_a[DW-1]}}, data_out_a})
                  * $signed({{DW{data_out_b[DW-1]}}, data_out_b});
    assign w_prod_ext = RW'(w_prod);
`else
    logic [2*DW-1:0] w_prod;
    assign w_prod = {{DW{1'b0}}, data_out_a} * {{DW{1'b0}}, data_out_b};
    assign w_prod_ext = RW'(w_prod);
`endif

    assign w_last_elem = (r_i == I_LAST) && (r_j == J_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_i        <= '0;
            r_j        <= '0;
            r_k        <= '0;
            r_acc      <= '0;
            r_prod_vld <= 1'b0;
        end else begin
            r_state    <= w_next;
            // Read data for a FETCH cycle arrives one cycle later.
            r_prod_vld <= (r_state == S_FETCH);
            if ((r_state == S_WRITE) || ((r_state == S_IDLE) && start)) begin
                r_acc <= '0;
            end else if (r_prod_vld) begin
                r_acc <= r_acc + w_prod_ext;
            end
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_i <= '0;
                        r_j <= '0;
                        r_k <= '0;
                    end
                end
                S_FETCH: begin
                    if (r_k != K_LAST) r_k <= r_k + 1'b1;
                end
                S_WRITE: begin
                    // Counters freeze on the final element so addresses hold.
                    if (!w_last_elem) begin
                        r_k <= '0;
                        if (r_j == J_LAST) begin
                            r_j <= '0;
                            r_i <= r_i + 1'b1;
                        end else begin
                            r_j <= r_j + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next      = r_state;
        busy        = (r_state != S_IDLE);
        done        = 1'b0;
        matrix_a_re = 1'b0;
        matrix_b_re = 1'b0;
        matrix_c_we = 1'b0;
        data_in_c   = '0;
        case (r_state)
            S_IDLE:  if (start) w_next = S_FETCH;
            S_FETCH: begin
                matrix_a_re = 1'b1;
                matrix_b_re = 1'b1;
                if (r_k == K_LAST) w_next = S_DRAIN;
            end
            S_DRAIN: w_next = S_WRITE;
            S_WRITE: begin
                matrix_c_we = 1'b1;
                data_in_c   = r_acc;
                w_next      = w_last_elem ? S_DONE : S_FETCH;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign row_addr_a = r_i;
    assign col_addr_a = r_k;
    assign row_addr_b = r_k;
    assign col_addr_b = r_j;
    assign row_addr_c = r_i;
    assign col_addr_c = r_j;
    assign dbg_state  = r_state;

endmodule

`default_nettype wire

// File: tb/tb_mac_stop_seq.sv
// Self-checking bench for mac_stop_seq: registered-read A/B memory model, C write capture,
// and a plain-arithmetic matrix-product reference.
`timescale 1ns/1ps

module tb_mac_stop_seq;

    localparam int M  = 4;
    localparam int K  = 4;
    localparam int N  = 4;
    localparam int DW = 32;
    localparam int RW = 2*DW + $clog2(K);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          busy, done;
    logic [1:0]    row_addr_a, col_addr_a, row_addr_b, col_addr_b, row_addr_c, col_addr_c;
    logic          matrix_a_re, matrix_b_re, matrix_c_we;
    logic [DW-1:0] data_out_a = '0;
    logic [DW-1:0] data_out_b = '0;
    logic [RW-1:0] data_in_c;
    logic [2:0]    dbg_state;

    logic [DW-1:0] mat_a [M][K];
    logic [DW-1:0] mat_b [K][N];
    logic [RW+3:0] got_q [$];
    logic [RW-1:0] exp_q [$];
    int            done_cnt, re_cnt, re_mis;
    int            errors = 0;
    int            checks = 0;

    mac_stop_seq dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .row_addr_a(row_addr_a), .col_addr_a(col_addr_a), .matrix_a_re(matrix_a_re),
        .data_out_a(data_out_a),
        .row_addr_b(row_addr_b), .col_addr_b(col_addr_b), .matrix_b_re(matrix_b_re),
        .data_out_b(data_out_b),
        .row_addr_c(row_addr_c), .col_addr_c(col_addr_c), .matrix_c_we(matrix_c_we),
        .data_in_c(data_in_c), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // Memory with one-cycle registered read.
    always @(posedge clk) begin
        if (matrix_a_re) data_out_a <= mat_a[row_addr_a][col_addr_a];
        if (matrix_b_re) data_out_b <= mat_b[row_addr_b][col_addr_b];
    end

    always @(negedge clk) begin
        if (matrix_c_we) got_q.push_back({row_addr_c, col_addr_c, data_in_c});
        if (done) done_cnt++;
        if (matrix_a_re) re_cnt++;
        if (matrix_a_re !== matrix_b_re) re_mis++;
    end

    function automatic logic [RW-1:0] model_elem(input int i, input int j);
        logic [RW-1:0] acc;
`ifdef MAC_STOP_SEQ_SIGNED_EN
        logic signed [RW-1:0] sa, sb;
`endif
        acc = '0;
        for (int k = 0; k < K; k++) begin
`ifdef MAC_STOP_SEQ_SIGNED_EN
            sa  = $signed(mat_a[i][k]);
            sb  = $signed(mat_b[k][j]);
            acc = acc + RW'(sa * sb);
`else
            acc = acc + RW'(mat_a[i][k]) * RW'(mat_b[k][j]);
`endif
        end
        return acc;
    endfunction

    task automatic build_exp();
        exp_q.delete();
        for (int i = 0; i < M; i++)
            for (int j = 0; j < N; j++)
                exp_q.push_back(model_elem(i, j));
    endtask

    task automatic fill_random(input int maxv);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                mat_a[r][c] = (maxv == 0) ? $urandom : $urandom_range(0, maxv);
                mat_b[r][c] = (maxv == 0) ? $urandom : $urandom_range(0, maxv);
            end
    endtask

    // Pulses start, then runs until done (or a reset injected at cycle reset_at).
    // Cycle 1 is the cycle right after the edge that accepts start.
    task automatic run_pass(input int restart_at, input int reset_at,
                            output int done_at, output bit timed_out);
        got_q.delete();
        done_cnt  = 0;
        re_cnt    = 0;
        re_mis    = 0;
        done_at   = 0;
        timed_out = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 400; c++) begin
            if (done) begin
                done_at   = c;
                timed_out = 1'b0;
                break;
            end
            if (c == reset_at) begin
                reset = 1'b1;
                @(negedge clk);
                timed_out = 1'b0;
                break;
            end
            start = (c == restart_at);
            @(negedge clk);
        end
        start = 1'b0;
        if (reset_at == 0) repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b want 0", done); end
        checks++; if ({matrix_a_re, matrix_b_re, matrix_c_we} !== 3'b000) begin errors++;
            $display("FAIL reset_en: got %b want 000", {matrix_a_re, matrix_b_re, matrix_c_we}); end
        checks++; if (data_in_c !== '0) begin errors++; $display("FAIL reset_data_c: got %0d want 0", data_in_c); end
        checks++; if ({row_addr_a, col_addr_a, row_addr_b, col_addr_b, row_addr_c, col_addr_c} !== 12'd0) begin errors++;
            $display("FAIL reset_addr: got %h want 000", {row_addr_a, col_addr_a, row_addr_b, col_addr_b, row_addr_c, col_addr_c}); end
        checks++; if (dbg_state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
        reset = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %0b want 0", busy); end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL start_busy: got %0b want 1", busy); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_abort_busy: got %0b want 0", busy); end
    endtask

    task automatic test_directed();
        int da;
        bit to;
        logic [RW-1:0] c_ref [16];
        mat_a = '{'{4,3,2,5}, '{3,4,5,2}, '{5,2,4,3}, '{2,5,3,4}};
        mat_b = '{'{7,6,5,8}, '{6,7,8,5}, '{8,5,7,6}, '{5,8,6,7}};
        c_ref = '{87,95,88,94, 95,87,94,88, 94,88,87,95, 88,94,95,87};
        exp_q.delete();
        for (int n = 0; n < 16; n++) exp_q.push_back(c_ref[n]);
        run_pass(0, 0, da, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL directed_timeout: got timeout want done"); end
        checks++; if (da != 97) begin errors++; $display("FAIL directed_done_cycle: got %0d want 97", da); end
        checks++; if (got_q.size() != 16) begin errors++; $display("FAIL directed_we_count: got %0d want 16", got_q.size()); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL directed_done_pulses: got %0d want 1", done_cnt); end
        checks++; if (re_cnt != M*N*K) begin errors++; $display("FAIL directed_re_cycles: got %0d want %0d", re_cnt, M*N*K); end
        checks++; if (re_mis != 0) begin errors++; $display("FAIL directed_re_pair: got %0d mismatched cycles want 0", re_mis); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL directed_idle_busy: got %0b want 0", busy); end
        for (int n = 0; n < got_q.size() && n < 16; n++) begin
            checks++;
            if (got_q[n] !== {2'(n / N), 2'(n % N), exp_q[n]}) begin errors++;
                $display("FAIL directed_c[%0d]: got addr %0d,%0d data %0d want addr %0d,%0d data %0d", n,
                         got_q[n][RW+3:RW+2], got_q[n][RW+1:RW], got_q[n][RW-1:0], n / N, n % N, exp_q[n]); end
        end
    endtask

    task automatic test_all_ones();
        int da;
        bit to;
        logic [RW-1:0] want;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                mat_a[r][c] = 32'hFFFF_FFFF;
                mat_b[r][c] = 32'hFFFF_FFFF;
            end
`ifdef MAC_STOP_SEQ_SIGNED_EN
        want = RW'(4);
`else
        want = RW'(4) * (RW'(32'hFFFF_FFFF) * RW'(32'hFFFF_FFFF));
`endif
        run_pass(0, 0, da, to);
        checks++; if (to !== 1'b0 || got_q.size() != 16) begin errors++;
            $display("FAIL ones_count: got %0d writes want 16", got_q.size()); end
        for (int n = 0; n < got_q.size() && n < 16; n++) begin
            checks++;
            if (got_q[n][RW-1:0] !== want) begin errors++;
                $display("FAIL ones_c[%0d]: got %0d want %0d", n, got_q[n][RW-1:0], want); end
        end
    endtask

    task automatic test_random();
        int da;
        bit to;
        for (int it = 0; it < 3; it++) begin
            fill_random((it == 0) ? 0 : 255);
            build_exp();
            run_pass(0, 0, da, to);
            checks++; if (to !== 1'b0 || da != 97) begin errors++;
                $display("FAIL random%0d_done_cycle: got %0d want 97", it, da); end
            checks++; if (got_q.size() != 16) begin errors++;
                $display("FAIL random%0d_we_count: got %0d want 16", it, got_q.size()); end
            for (int n = 0; n < got_q.size() && n < 16; n++) begin
                checks++;
                if (got_q[n] !== {2'(n / N), 2'(n % N), exp_q[n]}) begin errors++;
                    $display("FAIL random%0d_c[%0d]: got %0d want %0d", it, n, got_q[n][RW-1:0], exp_q[n]); end
            end
        end
    endtask

    task automatic test_restart_ignored();
        int da;
        bit to;
        fill_random(1000);
        build_exp();
        run_pass(20, 0, da, to);
        checks++; if (to !== 1'b0 || da != 97) begin errors++;
            $display("FAIL restart_done_cycle: got %0d want 97", da); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL restart_done_pulses: got %0d want 1", done_cnt); end
        checks++; if (got_q.size() != 16) begin errors++; $display("FAIL restart_we_count: got %0d want 16", got_q.size()); end
        for (int n = 0; n < got_q.size() && n < 16; n++) begin
            checks++;
            if (got_q[n] !== {2'(n / N), 2'(n % N), exp_q[n]}) begin errors++;
                $display("FAIL restart_c[%0d]: got %0d want %0d", n, got_q[n][RW-1:0], exp_q[n]); end
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL restart_idle_busy: got %0b want 0", busy); end
    endtask

    task automatic test_reset_abort();
        int da;
        bit to;
        fill_random(65535);
        build_exp();
        run_pass(0, 30, da, to);
        checks++; if ({busy, done, matrix_a_re, matrix_b_re, matrix_c_we} !== 5'b0) begin errors++;
            $display("FAIL abort_ctrl: got %b want 00000", {busy, done, matrix_a_re, matrix_b_re, matrix_c_we}); end
        checks++; if (data_in_c !== '0) begin errors++; $display("FAIL abort_data_c: got %0d want 0", data_in_c); end
        checks++; if ({row_addr_a, col_addr_a, row_addr_b, col_addr_b, row_addr_c, col_addr_c} !== 12'd0) begin errors++;
            $display("FAIL abort_addr: got %h want 000", {row_addr_a, col_addr_a, row_addr_b, col_addr_b, row_addr_c, col_addr_c}); end
        reset = 1'b0;
        repeat (10) @(negedge clk);
        checks++; if (got_q.size() != 5) begin errors++; $display("FAIL abort_we_count: got %0d want 5", got_q.size()); end
        checks++; if (done_cnt != 0) begin errors++; $display("FAIL abort_done: got %0d pulses want 0", done_cnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_stays_idle: got %0b want 0", busy); end
        for (int n = 0; n < got_q.size() && n < 5; n++) begin
            checks++;
            if (got_q[n] !== {2'(n / N), 2'(n % N), exp_q[n]}) begin errors++;
                $display("FAIL abort_partial_c[%0d]: got %0d want %0d", n, got_q[n][RW-1:0], exp_q[n]); end
        end
        run_pass(0, 0, da, to);
        checks++; if (to !== 1'b0 || da != 97 || got_q.size() != 16) begin errors++;
            $display("FAIL abort_rerun: got done %0d writes %0d want 97 and 16", da, got_q.size()); end
        for (int n = 0; n < got_q.size() && n < 16; n++) begin
            checks++;
            if (got_q[n] !== {2'(n / N), 2'(n % N), exp_q[n]}) begin errors++;
                $display("FAIL abort_rerun_c[%0d]: got %0d want %0d", n, got_q[n][RW-1:0], exp_q[n]); end
        end
    endtask

`ifdef MAC_STOP_SEQ_SIGNED_EN
    task automatic test_signed();
        int da;
        bit to;
        fill_random(0);
        mat_a[0] = '{32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFD, 32'd4};
        for (int k = 0; k < K; k++) mat_b[k][0] = 32'd1;
        build_exp();
        run_pass(0, 0, da, to);
        checks++; if (to !== 1'b0 || got_q.size() != 16) begin errors++;
            $display("FAIL signed_count: got %0d writes want 16", got_q.size()); end
        if (got_q.size() > 0) begin
            checks++;
            if (got_q[0][RW-1:0] !== RW'(2)) begin errors++;
                $display("FAIL signed_c00: got %0d want 2", got_q[0][RW-1:0]); end
        end
        for (int n = 0; n < got_q.size() && n < 16; n++) begin
            checks++;
            if (got_q[n][RW-1:0] !== exp_q[n]) begin errors++;
                $display("FAIL signed_c[%0d]: got %h want %h", n, got_q[n][RW-1:0], exp_q[n]); end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_all_ones();
        test_random();
        test_restart_ignored();
        test_reset_abort();
`ifdef MAC_STOP_SEQ_SIGNED_EN
        test_signed();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
